id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register with built-in load-use hazard detection. It captures decoded operands and control from the decode stage and presents them to the execute stage. The Rs1/Rs2 outputs feed the forwarding unit's source-register inputs. It inserts exactly one bubble on a load-use dependency, holds while memory is busy, and squashes on flush. It also drives the stall request that freezes PC and IF/ID.

## Interface
- XLEN, 32, datapath width
- CNT_W, 16, width of the bubble counter
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- id_valid_i  in  1  decode stage holds a real instruction
- Rs1_i, Rs2_i, Rd_i  in  5 each  register indices from decode
- Rs1_use_i, Rs2_use_i  in  1 each  instruction actually reads Rs1/Rs2
- RegWrite_i, MemRead_i, MemWrite_i, MemtoReg_i, ALUSrc_i  in  1 each  control from decode
- ALUOp_i  in  2  ALU op class
- funct_i  in  10  {funct7, funct3}
- rs1_data_i, rs2_data_i, imm_i  in  XLEN each  operand values
- flush_i  in  1  squash the decode-stage instruction
- mem_stall_i  in  1  downstream memory busy; freeze this stage
- ex_valid_o, Rs1_o, Rs2_o, Rd_o, RegWrite_o, MemRead_o, MemWrite_o, MemtoReg_o, ALUSrc_o, ALUOp_o, funct_o, rs1_data_o, rs2_data_o, imm_o  out  same widths  registered execute-stage copies
- hazard_stall_o  out  1  freeze PC and IF/ID this cycle (combinational)
- bubble_cnt_o  out  CNT_W  count of load-use bubbles inserted, saturating

## Operation
- Bubble: all outputs zero (ex_valid_o=0, Rd_o=0, every control bit 0, all data fields 0).
- Hazard detection (combinational, from registered state and ID inputs):
  - hazard_stall_o = id_valid_i & ex_valid_o & MemRead_o & (Rd_o≠0) & ((Rs1_use_i & Rs1_i==Rd_o) | (Rs2_use_i & Rs2_i==Rd_o)).
  - Rd_o=0 never raises a hazard.
  - A register with no use flag never raises a hazard.
- Per-edge update, highest priority first:
  1. rst_i: load bubble, bubble_cnt_o←0.
  2. mem_stall_i: hold all registers, including the counter.
  3. flush_i, or !id_valid_i: load bubble. The counter does not increment.
  4. hazard_stall_o: load bubble; bubble_cnt_o increments, saturating at all-ones.
  5. Otherwise: capture all ID inputs; ex_valid_o←1.
- A load-use dependency yields exactly one bubble. Next cycle EX holds a bubble, so hazard_stall_o drops and the held instruction enters. Forwarding then covers it from MEM/WB.
- flush_i together with hazard_stall_o: load bubble (rule 3); counter unchanged. hazard_stall_o still asserts combinationally, and upstream gives flush priority.
- mem_stall_i with flush_i: hold (rule 2). Upstream keeps flush_i asserted until the stall clears.
- Reset mid-stall or mid-hazard: the bubble takes effect at the next edge, and hazard_stall_o is 0 the cycle after.

## Timing
- Reset values: every output 0, including hazard_stall_o (since ex_valid_o=0) and bubble_cnt_o.
- Latency: an ID input captured at edge N is visible on the outputs after edge N until the next update.
- hazard_stall_o is valid in the same cycle as the ID inputs. There are no registered paths from inputs to hazard_stall_o.
- One load-use dependency gives one cycle of hazard_stall_o=1 and one bubble, unless mem_stall_i extends it. Under mem_stall_i, hazard_stall_o stays asserted for as long as the condition holds.
- No combinational path from any input to any registered output.

## Test plan
- Reset: hold rst_i 2 cycles with random ID inputs -> all outputs 0, bubble_cnt_o=0; first non-hazard edge after release captures inputs, ex_valid_o=1.
- Load-use: `lw x5` captured (MemRead_o=1, Rd_o=5); next ID is `add x6,x5,x7` with Rs1_use_i=1 -> hazard_stall_o=1 for one cycle. Next edge loads a bubble with bubble_cnt_o=1. The following edge captures the add with Rs1_o=5.
- No false hazard:
  - `lw x0` followed by a reader of x0 -> hazard_stall_o=0.
  - `lw x5` then `lui x5` (Rs1_use_i=0, Rs2_use_i=0, Rs1_i=5) -> hazard_stall_o=0.
  - `add x5` (MemRead=0) then a reader of x5 -> hazard_stall_o=0.
- mem_stall_i high 3 cycles with new ID inputs and flush_i=1 -> outputs and counter unchanged for all 3 edges. On release, a bubble loads because flush_i is still high.
- Flush + hazard in same cycle -> bubble loaded, bubble_cnt_o unchanged.
- Counter saturation: force 2^CNT_W+2 hazard bubbles -> bubble_cnt_o stops at 0xFFFF and never wraps.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and bubble counting
// Ports: clk_i/rst_i (sync active-high); id_* decode inputs (indices, use flags, control, operands);
//   flush_i squashes the decode instruction; mem_stall_i freezes the stage;
//   *_o registered execute-stage copies; hazard_stall_o (combinational) freezes PC and IF/ID;
//   bubble_cnt_o saturating count of load-use bubbles.
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [4:0]       Rs1_i,
  input  logic [4:0]       Rs2_i,
  input  logic [4:0]       Rd_i,
  input  logic             Rs1_use_i,
  input  logic             Rs2_use_i,
  input  logic             RegWrite_i,
  input  logic             MemRead_i,
  input  logic             MemWrite_i,
  input  logic             MemtoReg_i,
  input  logic             ALUSrc_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [9:0]       funct_i,
  input  logic [XLEN-1:0]  rs1_data_i,
  input  logic [XLEN-1:0]  rs2_data_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             flush_i,
  input  logic             mem_stall_i,
  output logic             ex_valid_o,
  output logic [4:0]       Rs1_o,
  output logic [4:0]       Rs2_o,
  output logic [4:0]       Rd_o,
  output logic             RegWrite_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             MemtoReg_o,
  output logic             ALUSrc_o,
  output logic [1:0]       ALUOp_o,
  output logic [9:0]       funct_o,
  output logic [XLEN-1:0]  rs1_data_o,
  output logic [XLEN-1:0]  rs2_data_o,
  output logic [XLEN-1:0]  imm_o,
  output logic             hazard_stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);
  logic load;
  logic bump;
  always_comb begin
    hazard_stall_o = id_valid_i & ex_valid_o & MemRead_o & (Rd_o != 5'd0) &
                     ((Rs1_use_i & (Rs1_i == Rd_o)) | (Rs2_use_i & (Rs2_i == Rd_o)));
    load = id_valid_i & ~flush_i & ~hazard_stall_o;
    // A flushed hazard still becomes a bubble but is not counted as a load-use bubble.
    bump = hazard_stall_o & ~flush_i & ~&bubble_cnt_o;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_valid_o   <= 1'b0;
      Rs1_o        <= '0;
      Rs2_o        <= '0;
      Rd_o         <= '0;
      RegWrite_o   <= 1'b0;
      MemRead_o    <= 1'b0;
      MemWrite_o   <= 1'b0;
      MemtoReg_o   <= 1'b0;
      ALUSrc_o     <= 1'b0;
      ALUOp_o      <= '0;
      funct_o      <= '0;
      rs1_data_o   <= '0;
      rs2_data_o   <= '0;
      imm_o        <= '0;
      bubble_cnt_o <= '0;
    end else if (!mem_stall_i) begin
      ex_valid_o   <= load;
      Rs1_o        <= load ? Rs1_i : '0;
      Rs2_o        <= load ? Rs2_i : '0;
      Rd_o         <= load ? Rd_i : '0;
      RegWrite_o   <= load & RegWrite_i;
      MemRead_o    <= load & MemRead_i;
      MemWrite_o   <= load & MemWrite_i;
      MemtoReg_o   <= load & MemtoReg_i;
      ALUSrc_o     <= load & ALUSrc_i;
      ALUOp_o      <= load ? ALUOp_i : '0;
      funct_o      <= load ? funct_i : '0;
      rs1_data_o   <= load ? rs1_data_i : '0;
      rs2_data_o   <= load ? rs2_data_i : '0;
      imm_o        <= load ? imm_i : '0;
      bubble_cnt_o <= bump ? bubble_cnt_o + 1'b1 : bubble_cnt_o;
    end
  end
endmodule
